// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: upstream controller for a 16-bit accumulate-style
// multiplier. Operand pairs are buffered in a small FIFO, issued one at a
// time (clear accumulator, start pulse, wait for done) and the 32-bit product
// is returned on a valid/ready sink. Jobs with a zero operand are answered
// locally because the multiplier never completes when arg2 is zero.
//
// Optional feature: define MULT_SEQ_SWAP_MIN_EN to present the smaller
// operand as arg2 so the multiplier accumulates min(a,b) times.
module mult_job_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_product,
  output logic             mul_res_n,
  output logic             mul_start,
  output logic [15:0]      mul_arg1,
  output logic [15:0]      mul_arg2,
  input  logic             mul_done,
  input  logic [31:0]      mul_product,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]      r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_fifo_cnt;

  // FSM state and registered outputs
  state_t           r_state;
  logic             r_wait_first;
  logic             r_out_valid;
  logic [31:0]      r_out_product;
  logic             r_mul_res_n;
  logic             r_mul_start;
  logic [15:0]      r_mul_arg1;
  logic [15:0]      r_mul_arg2;
  logic             r_busy;
  logic [CNT_W-1:0] r_job_count;

  // Combinational next values
  state_t           w_state_nx;
  logic             w_wait_first_nx;
  logic             w_out_valid_nx;
  logic [31:0]      w_out_product_nx;
  logic             w_mul_res_n_nx;
  logic             w_mul_start_nx;
  logic [15:0]      w_mul_arg1_nx;
  logic [15:0]      w_mul_arg2_nx;
  logic [CNT_W-1:0] w_job_count_nx;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_head;
  logic [15:0]      w_head_a;
  logic [15:0]      w_head_b;
  logic             w_swap;
  logic [15:0]      w_op1;
  logic [15:0]      w_op2;

  assign w_full   = (r_fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty  = (r_fifo_cnt == '0);
  assign in_ready = !w_full && !res;
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_fifo_mem[r_rd_ptr];
  assign w_head_a = w_head[31:16];
  assign w_head_b = w_head[15:0];

`ifdef MULT_SEQ_SWAP_MIN_EN
  // Smaller operand becomes the accumulation count to shorten the run.
  assign w_swap = (w_head_a < w_head_b);
`else
  assign w_swap = 1'b0;
`endif

  assign w_op1 = w_swap ? w_head_b : w_head_a;
  assign w_op2 = w_swap ? w_head_a : w_head_b;

  // FIFO storage write; contents need no reset since the count gates reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; a pop never frees a slot for the same cycle's push
  always_ff @(posedge clk) begin
    if (res) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Next-state and next-output decode for the job issue FSM
  always_comb begin
    w_state_nx       = r_state;
    w_wait_first_nx  = 1'b0;
    w_out_valid_nx   = r_out_valid;
    w_out_product_nx = r_out_product;
    w_mul_res_n_nx   = 1'b1;
    w_mul_start_nx   = 1'b0;
    w_mul_arg1_nx    = r_mul_arg1;
    w_mul_arg2_nx    = r_mul_arg2;
    w_job_count_nx   = r_job_count;
    w_pop            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if ((w_head_a == 16'd0) || (w_head_b == 16'd0)) begin
            w_out_product_nx = 32'd0;
            w_out_valid_nx   = 1'b1;
            w_state_nx       = ST_HOLD;
          end else begin
            w_mul_res_n_nx = 1'b0;
            w_mul_arg1_nx  = w_op1;
            w_mul_arg2_nx  = w_op2;
            w_state_nx     = ST_CLEAR;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_mul_start_nx = 1'b1;
        w_state_nx     = ST_START;
      end
      ST_START: begin
        w_wait_first_nx = 1'b1;
        w_state_nx      = ST_WAIT;
      end
      ST_WAIT: begin
        // done may still be high from the previous job on the first cycle
        if (!r_wait_first && mul_done) begin
          w_out_product_nx = mul_product;
          w_out_valid_nx   = 1'b1;
          w_state_nx       = ST_HOLD;
        end else begin
          w_state_nx = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_out_valid_nx = 1'b0;
          w_job_count_nx = r_job_count + 1'b1;
          w_state_nx     = ST_IDLE;
        end else begin
          w_state_nx = ST_HOLD;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight job
  always_ff @(posedge clk) begin
    if (res) begin
      r_state       <= ST_IDLE;
      r_wait_first  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_product <= 32'd0;
      r_mul_res_n   <= 1'b0;
      r_mul_start   <= 1'b0;
      r_mul_arg1    <= 16'd0;
      r_mul_arg2    <= 16'd0;
      r_busy        <= 1'b0;
      r_job_count   <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_wait_first  <= w_wait_first_nx;
      r_out_valid   <= w_out_valid_nx;
      r_out_product <= w_out_product_nx;
      r_mul_res_n   <= w_mul_res_n_nx;
      r_mul_start   <= w_mul_start_nx;
      r_mul_arg1    <= w_mul_arg1_nx;
      r_mul_arg2    <= w_mul_arg2_nx;
      r_busy        <= (w_state_nx != ST_IDLE);
      r_job_count   <= w_job_count_nx;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign mul_res_n   = r_mul_res_n;
  assign mul_start   = r_mul_start;
  assign mul_arg1    = r_mul_arg1;
  assign mul_arg2    = r_mul_arg2;
  assign busy        = r_busy;
  assign job_count   = r_job_count;

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
- Upstream controller for the 16-bit accumulate-style multiplier.
- Buffers operand pairs from a valid/ready source in a small FIFO.
- Issues each job to the multiplier: clears its accumulator, pulses start, holds the operands stable, waits for done.
- Returns the 32-bit product to a valid/ready sink. Zero-operand jobs are resolved locally, because the multiplier never completes with arg2 = 0.

Parameters:
FIFO_DEPTH, 4, operand FIFO entries; power of 2, minimum 2
CNT_W, 16, width of job_count

Ports:
clk  in  1  system clock; all logic on posedge
res  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept a pair
in_a  in  16  multiplicand
in_b  in  16  multiplier operand
out_valid  out  1  product valid
out_ready  in  1  sink accepts product
out_product  out  32  result in_a*in_b, unsigned
mul_res_n  out  1  active-low accumulator reset to multiplier
mul_start  out  1  start pulse to multiplier
mul_arg1  out  16  operand to multiplier arg1
mul_arg2  out  16  operand to multiplier arg2 (accumulation count)
mul_done  in  1  multiplier done
mul_product  in  32  multiplier product
busy  out  1  high in any state other than IDLE
job_count  out  CNT_W  completed jobs (output handshakes)

Behaviour:
- Interface: one clock `clk`; reset `res` is synchronous and active-high.
- Reset values while res = 1:
  - out_valid=0, out_product=0, in_ready=0.
  - mul_res_n=0, mul_start=0, mul_arg1=mul_arg2=0.
  - busy=0, job_count=0, FIFO emptied, state=IDLE.
- Reset mid-operation: all queued and in-flight jobs are discarded, with no partial output. mul_res_n goes low on the same edge.
- FIFO:
  - in_ready = !full, combinational from registered count; res forces it to 0.
  - Push on in_valid && in_ready.
  - Pop happens only in IDLE. A push into a full FIFO is impossible because a same-cycle pop does not free a slot for that cycle's push.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine, registered outputs:
  - IDLE: if FIFO not empty, pop the head into the job register (a, b).
    - If a==0 or b==0: out_product<=0, out_valid<=1, go to HOLD, with no multiplier activity.
    - Otherwise go to CLEAR.
  - CLEAR (1 cycle): mul_res_n=0; mul_arg1/mul_arg2 driven with job operands. Then go to START.
  - START (1 cycle): mul_res_n=1, mul_start=1. Then go to WAIT.
  - WAIT: mul_start=0.
    - mul_done is ignored in the first WAIT cycle, since it can still be stale from the previous job.
    - From the second cycle on, when mul_done=1: out_product<=mul_product, out_valid<=1, go to HOLD.
  - HOLD: out_valid stays high and out_product stays stable until out_ready.
    - On handshake: out_valid<=0, job_count<=job_count+1 (wraps to 0 at all-ones), go to IDLE.
- mul_arg1/mul_arg2 stay constant from CLEAR through WAIT, because the multiplier compares against arg2 every cycle. They hold their last value in other states.
- mul_res_n=1 in all states except CLEAR and reset.
- Latency, pop to out_valid:
  - Zero job: 1 cycle.
  - Nonzero job: 1 (CLEAR) + 1 (START) + multiplier time + 1 capture. Roughly b+3 cycles; b is a+b-dependent only via the optional feature.
- Products are unsigned 32-bit. 0xFFFF*0xFFFF = 0xFFFE0001 with no overflow.
- Jobs complete strictly in FIFO order; one job is in flight at a time.

Optional Feature:
- Macro: MULT_SEQ_SWAP_MIN_EN.
- Defined: in IDLE, for a nonzero job, if a < b the operands are swapped (mul_arg1=b, mul_arg2=a). The multiplier then accumulates min(a,b) times. Product is unchanged, latency is reduced.
- Undefined: mul_arg1=a, mul_arg2=b always, and the comparator is not built.

Test Plan:
- Push (3,5), out_ready=1 → one mul_res_n low pulse, one mul_start pulse, mul_arg2=5; out_product=15 (0x0000000F); job_count=1.
- Push (0,7) then (7,0) → each gives out_product=0 one cycle after pop; mul_start never asserts.
- out_ready=0, push 5 jobs with FIFO_DEPTH=4 → in_ready drops after 4 accepted while job 1 is in HOLD. Then raise out_ready → results emerge in push order and in_ready re-asserts.
- Push (0xFFFF,0xFFFF) → out_product=0xFFFE0001. out_valid holds stable under 10 cycles of out_ready=0.
- Assert res for 1 cycle while in WAIT for job (4,100) → next cycle: out_valid=0, FIFO empty, job_count=0, mul_res_n=0. New job (2,3) then yields 6.
- With MULT_SEQ_SWAP_MIN_EN, push (2,1000) → mul_arg2=2, out_product=2000 within 8 cycles of pop. Without the macro → mul_arg2=1000, same product.
